// File: rtl/alu_result_display.sv
// alu_result_display: latches ALU result/flags on a synchronised button edge and drives the seg7 digit.
// Define ALU_DISP_FLAGS_EN to alternate result and flags every MAX_COUNT cycles; otherwise the result is held.
module alu_result_display #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] result,
    input  logic [3:0] flags,
    input  logic       capture,
    output logic [3:0] digit,
    output logic       dp,
    output logic       blank,
    output logic [3:0] cap_count
);
`ifdef ALU_DISP_FLAGS_EN
    typedef enum logic [1:0] {IDLE, SHOW_RES, SHOW_FLG} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW_RES} state_t;
`endif
    state_t state_q, state_d;
    logic sync1_q, sync2_q, prev_q;
    logic cap_pulse;
    logic [3:0] res_q, res_d;
    logic [3:0] capc_q, capc_d;
`ifdef ALU_DISP_FLAGS_EN
    logic [3:0] flg_q, flg_d;
    logic [23:0] phase_q, phase_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{flags, MAX_COUNT};
`endif

    assign cap_pulse = sync2_q & ~prev_q;

    // A capture overrides the terminal-count toggle and restarts the phase.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        capc_d  = capc_q;
`ifdef ALU_DISP_FLAGS_EN
        flg_d   = flg_q;
        phase_d = '0;
        if (state_q != IDLE) begin
            phase_d = (phase_q == MAX_COUNT - 24'd1) ? 24'd0 : phase_q + 24'd1;
            if (phase_q == MAX_COUNT - 24'd1)
                state_d = (state_q == SHOW_RES) ? SHOW_FLG : SHOW_RES;
        end
`endif
        if (cap_pulse) begin
            state_d = SHOW_RES;
            res_d   = result;
            capc_d  = capc_q + 4'd1;
`ifdef ALU_DISP_FLAGS_EN
            flg_d   = flags;
            phase_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= IDLE;
            res_q   <= '0;
            capc_q  <= '0;
`ifdef ALU_DISP_FLAGS_EN
            flg_q   <= '0;
            phase_q <= '0;
`endif
        end else begin
            sync1_q <= capture;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            res_q   <= res_d;
            capc_q  <= capc_d;
`ifdef ALU_DISP_FLAGS_EN
            flg_q   <= flg_d;
            phase_q <= phase_d;
`endif
        end
    end

    always_comb begin
        digit = (state_q == SHOW_RES) ? res_q : 4'd0;
        dp    = 1'b0;
`ifdef ALU_DISP_FLAGS_EN
        digit = (state_q == SHOW_FLG) ? flg_q : digit;
        dp    = (state_q == SHOW_FLG);
`endif
        blank = (state_q == IDLE);
    end

    assign cap_count = capc_q;
endmodule
